count_sequencer: RTL
====================

Name: count_sequencer

Overview:
- Upstream source for the 2-bit register stage: generates the `count` bus and the `status` force-reset flag that the register stage consumes.
- Programmable up/down modulo counter with enable, parallel load and a wrap-counting FSM.
- `status` asserts after a configured number of wrap-arounds and holds until cleared or restarted.
- Sits between the control logic (start/clear/enable) and the register stage.

Parameters:
- WIDTH, 2, counter width; `count` wraps modulo 2^WIDTH.
- WRAP_LIMIT, 2, wrap events required to finish a run; legal range 1..255.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  begin a run; sampled in IDLE and DONE only.
- start_value  input  WIDTH  count value loaded on start.
- enable  input  1  advance the counter one step per cycle while in RUN.
- up_down  input  1  1 = increment, 0 = decrement; sampled every step.
- load  input  1  parallel load during RUN.
- load_value  input  WIDTH  value loaded when load=1.
- clear  input  1  acknowledge DONE; return to IDLE.
- count  output  WIDTH  current count, registered; feeds the register stage.
- status  output  1  run complete, registered level; feeds the register stage force-reset.
- busy  output  1  high while in RUN.
- wrap_count  output  8  wrap events seen in the current run.

Behaviour:
- Reset (async, active-high):
  - count=0, status=0, busy=0, wrap_count=0, state=IDLE.
  - Takes effect immediately, no clock needed; reset mid-run aborts the run with no residue.
- All outputs are registered; every change is visible one cycle after the causing input edge.
- States: IDLE, RUN, DONE.
- IDLE:
  - count holds; status=0; busy=0.
  - start=1: count<=start_value, wrap_count<=0, go to RUN.
- RUN (busy=1). Priority order each cycle:
  1. load=1: count<=load_value. No wrap, no wrap_count change; enable ignored that cycle.
  2. Else enable=1: count<=count±1 modulo 2^WIDTH.
     - Wrap event = up step from all-ones, or down step from 0.
  3. Else: count holds.
- Wrap handling in RUN:
  - Each wrap event increments wrap_count.
  - If the wrap brings wrap_count to WRAP_LIMIT: same edge sets status=1, busy=0, state=DONE.
  - The count stored on that edge is the wrapped value (0 for up, all-ones for down).
- start in RUN is ignored; there is no mid-run restart except reset.
- clear in RUN is ignored.
- DONE:
  - count and wrap_count hold; status=1; busy=0; enable and load are ignored.
  - start=1 (priority over clear): count<=start_value, wrap_count<=0, status<=0, go to RUN.
  - Else clear=1: status<=0, go to IDLE; count holds.
- up_down may change on any cycle; each step uses the value sampled on that edge.
- wrap_count never exceeds WRAP_LIMIT.

Test Plan:
- Reset during RUN: reset=1 mid-count with count=10 -> count=00, status=0, busy=0, wrap_count=0 before the next clk edge; state IDLE.
- Up run, WIDTH=2, WRAP_LIMIT=2: start, start_value=01, enable=1, up_down=1.
  - count sequence 01,10,11,00 (wrap_count=1),01,10,11,00.
  - On the second 11->00 edge: status=1, busy=0, wrap_count=2.
  - Further cycles: count stays 00, status stays 1.
- Down run: start_value=00, up_down=0, enable=1.
  - First step gives 11 with wrap_count=1.
  - Sequence 10,01,00, then the 00->11 edge sets status=1 with count=11.
- Enable and load in RUN:
  - enable=0 for 3 cycles at count=10 -> count holds 10, busy=1.
  - load=1, load_value=11, enable=1 -> count=11, wrap_count unchanged.
  - Next up step -> 00, wrap_count+1.
- DONE exit:
  - clear=1 in DONE -> status=0 and state IDLE next cycle, count unchanged.
  - Separate run: start=1 and clear=1 together in DONE, start_value=10 -> RUN, count=10, status=0, wrap_count=0.
- Ignored start: start=1 while RUN with count=01 -> no reload, counting continues 01->10.

Source files
------------

// File: rtl/count_sequencer.sv
// Up/down modulo counter with parallel load and a wrap-counting run FSM.
// Produces the count bus and the registered run-complete status flag.
module count_sequencer #(
  parameter int unsigned WIDTH      = 2,
  parameter int unsigned WRAP_LIMIT = 2
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] start_value_i,
  input  logic             enable_i,
  input  logic             up_down_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_value_i,
  input  logic             clear_i,
  output logic [WIDTH-1:0] count_o,
  output logic             status_o,
  output logic             busy_o,
  output logic [7:0]       wrap_count_o
);

  localparam logic [7:0] WrapLimit = 8'(WRAP_LIMIT);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [7:0]       wrap_q, wrap_d;
  logic             status_q, status_d;
  logic             wrap_event;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= StIdle;
      count_q  <= '0;
      wrap_q   <= '0;
      status_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      wrap_q   <= wrap_d;
      status_q <= status_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    wrap_d     = wrap_q;
    status_d   = status_q;
    wrap_event = 1'b0;
    unique case (state_q)
      StIdle: begin
        status_d = 1'b0;
        if (start_i) begin
          count_d = start_value_i;
          wrap_d  = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        if (load_i) begin
          count_d = load_value_i;
        end else if (enable_i) begin
          if (up_down_i) begin
            count_d    = count_q + 1'b1;
            wrap_event = &count_q;
          end else begin
            count_d    = count_q - 1'b1;
            wrap_event = ~|count_q;
          end
        end
        // The edge that reaches the limit also retires the run.
        if (wrap_event) begin
          wrap_d = wrap_q + 8'd1;
          if (wrap_d == WrapLimit) begin
            status_d = 1'b1;
            state_d  = StDone;
          end
        end
      end
      StDone: begin
        if (start_i) begin
          count_d  = start_value_i;
          wrap_d   = '0;
          status_d = 1'b0;
          state_d  = StRun;
        end else if (clear_i) begin
          status_d = 1'b0;
          state_d  = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign count_o      = count_q;
  assign status_o     = status_q;
  assign busy_o       = (state_q == StRun);
  assign wrap_count_o = wrap_q;

endmodule
